// File: rtl/reg_bank_responder_pkg.sv
// Shared definitions for the register bank responder: data/register geometry
// and the state encodings of the independent read and write FSMs.
package rb_pkg;

  localparam int DW    = 32;
  localparam int NREGS = 16;
  localparam int AW    = $clog2(NREGS);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_SYNC = 2'd1,
    RD_READ = 2'd2,
    RD_RESP = 2'd3
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_SYNC   = 2'd1,
    WR_COMMIT = 2'd2
  } wr_state_e;

endpackage

// File: rtl/reg_bank_responder_toggle_sync.sv
// toggle_sync: two-flop synchronizer for a request toggle plus the compare
// against the owner's acknowledge phase. raw_diff uses the unsynchronized
// toggle (for the combinational ready path and the IDLE wake-up), sync_diff
// uses the second synchronizer stage (safe to act on).
module toggle_sync (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  input  logic phase,
  output logic raw_diff,
  output logic sync_diff
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next-state of the synchronizer; under reset both stages preload the raw
  // toggle so no phantom request appears when reset drops.
  always_comb begin
    s1_d = trig;
    s2_d = s1_q;
    if (reset) begin
      s1_d = trig;
      s2_d = trig;
    end else begin
      s1_d = trig;
      s2_d = s1_q;
    end
  end

  // Synchronizer flops.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign raw_diff  = trig ^ phase;
  assign sync_diff = s2_q ^ phase;

endmodule

// File: rtl/reg_bank_responder.sv
// reg_bank_responder: flop-based register bank with one toggle-handshake read
// port and one toggle-handshake write port, each served by its own FSM.
// Optional macro RB_WR_BYPASS_EN: when a READ capture and a COMMIT hit the
// same index on the same edge, the read returns the value being written;
// without it the read returns the old register contents.
module reg_bank_responder
  import rb_pkg::*;
#(
  parameter int DW    = rb_pkg::DW,
  parameter int NREGS = rb_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_trig,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_ready,
  input  logic                     wr_trig,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [DW-1:0]            wr_data,
  output logic                     wr_ack
);

  rd_state_e    rd_state_q, rd_state_d;
  wr_state_e    wr_state_q, wr_state_d;
  logic         rd_phase_q, rd_phase_d;
  logic         wr_ack_q,   wr_ack_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic [DW-1:0] rd_src_s;
  logic         rd_raw_diff_s, rd_sync_diff_s;
  logic         wr_raw_diff_s, wr_sync_diff_s;
  logic         commit_s;

  toggle_sync u_rd_sync (
    .clk       (clk),
    .reset     (reset),
    .trig      (rd_trig),
    .phase     (rd_phase_q),
    .raw_diff  (rd_raw_diff_s),
    .sync_diff (rd_sync_diff_s)
  );

  toggle_sync u_wr_sync (
    .clk       (clk),
    .reset     (reset),
    .trig      (wr_trig),
    .phase     (wr_ack_q),
    .raw_diff  (wr_raw_diff_s),
    .sync_diff (wr_sync_diff_s)
  );

  assign commit_s = (wr_state_q == WR_COMMIT);

  // Read source: register contents, optionally bypassed by a same-edge commit.
  always_comb begin
    rd_src_s = regs_q[rd_addr];
`ifdef RB_WR_BYPASS_EN
    if (commit_s && (wr_addr == rd_addr)) begin
      rd_src_s = wr_data;
    end else begin
      rd_src_s = regs_q[rd_addr];
    end
`else
    rd_src_s = regs_q[rd_addr];
`endif
  end

  // Read FSM: wake on raw mismatch, act only once the synchronized toggle differs.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_data_d  = rd_data_q;
    rd_phase_d = rd_phase_q;
    if (reset) begin
      rd_state_d = RD_IDLE;
      rd_data_d  = '0;
      rd_phase_d = rd_trig;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (rd_raw_diff_s) rd_state_d = RD_SYNC;
          else               rd_state_d = RD_IDLE;
        end
        RD_SYNC: begin
          if (rd_sync_diff_s) rd_state_d = RD_READ;
          else                rd_state_d = RD_SYNC;
        end
        RD_READ: begin
          rd_data_d  = rd_src_s;
          rd_state_d = RD_RESP;
        end
        RD_RESP: begin
          rd_phase_d = ~rd_phase_q;
          rd_state_d = RD_IDLE;
        end
        default: rd_state_d = RD_IDLE;
      endcase
    end
  end

  // Write FSM: the commit and the acknowledge toggle happen on the same edge.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_ack_d   = wr_ack_q;
    if (reset) begin
      wr_state_d = WR_IDLE;
      wr_ack_d   = wr_trig;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (wr_raw_diff_s) wr_state_d = WR_SYNC;
          else               wr_state_d = WR_IDLE;
        end
        WR_SYNC: begin
          if (wr_sync_diff_s) wr_state_d = WR_COMMIT;
          else                wr_state_d = WR_SYNC;
        end
        WR_COMMIT: begin
          wr_ack_d   = ~wr_ack_q;
          wr_state_d = WR_IDLE;
        end
        default: wr_state_d = WR_IDLE;
      endcase
    end
  end

  // Register array next-state: clear under reset, otherwise a single commit write.
  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
    end else if (commit_s) begin
      regs_d[wr_addr] = wr_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // State, data and register-bank flops.
  always_ff @(posedge clk) begin
    rd_state_q <= rd_state_d;
    wr_state_q <= wr_state_d;
    rd_phase_q <= rd_phase_d;
    wr_ack_q   <= wr_ack_d;
    rd_data_q  <= rd_data_d;
    regs_q     <= regs_d;
  end

  // Ready drops as soon as the requester toggles, without waiting for a clock.
  assign rd_ready = ~(rd_trig ^ rd_phase_q);
  assign rd_data  = rd_data_q;
  assign wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_reg_bank_responder.sv
// Self-checking bench for reg_bank_responder: directed scenarios plus a
// randomized mix of reads/writes checked against an array model of the bank.
module tb_reg_bank_responder;

  logic        clk;
  logic        reset;
  logic        rd_trig;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic        wr_trig;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;

  int pass_cnt;
  int total_cnt;
  logic [31:0] ref_regs [16];

  reg_bank_responder dut (
    .clk      (clk),
    .reset    (reset),
    .rd_trig  (rd_trig),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .wr_trig  (wr_trig),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_regs[i] = 32'h0;
  endtask

  // Write: the first edge after the toggle samples it; wr_ack follows 3 edges
  // after that one, i.e. on the 4th edge counted from the toggle.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input string tag);
    int n;
    wr_addr = a;
    wr_data = d;
    wr_trig = ~wr_trig;
    n = 0;
    while ((wr_ack !== wr_trig) && (n < 20)) begin
      tick();
      n++;
    end
    check({tag, "_wr_latency"}, 64'(n), 64'd4);
    ref_regs[a] = d;
  endtask

  // Read: ready falls at once, rises 4 edges after the sampling edge.
  task automatic do_read(input logic [3:0] a, input string tag);
    int n;
    rd_addr = a;
    rd_trig = ~rd_trig;
    #1;
    check({tag, "_rdy_fall"}, 64'(rd_ready), 64'd0);
    n = 0;
    while ((rd_ready !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    check({tag, "_rd_latency"}, 64'(n), 64'd5);
    check({tag, "_rd_data"}, 64'(rd_data), 64'(ref_regs[a]));
  endtask

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] exp35;
    logic [3:0]  wa;
    logic [3:0]  ra;
    logic [31:0] wd;
    logic [31:0] old_rd;
    int          n;
    int          op;

    pass_cnt  = 0;
    total_cnt = 0;
    model_reset();

    // Reset with rd_trig high and wr_trig low.
    reset   = 1'b1;
    rd_trig = 1'b1;
    wr_trig = 1'b0;
    rd_addr = 4'd0;
    wr_addr = 4'd0;
    wr_data = 32'h0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("post_reset_ready", 64'(rd_ready), 64'd1);
    check("post_reset_ack",   64'(wr_ack),   64'd0);
    check("post_reset_data",  64'(rd_data),  64'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_no_phantom", {31'd0, rd_ready, 31'd0, wr_ack}, {31'd0, 1'b1, 32'd0});
      check("idle_data", 64'(rd_data), 64'd0);
    end
    for (int i = 0; i < 16; i++) do_read(4'(i), "reset_regs");

    // r5 write then read.
    do_write(4'd5, 32'hDEADBEEF, "r5");
    do_read(4'd5, "r5");

    // r0, r15 and neighbour r14.
    do_read(4'd0, "r0");
    do_write(4'd15, 32'h80000001, "r15");
    do_read(4'd15, "r15");
    do_read(4'd14, "r14_untouched");

    // Same-edge READ and COMMIT to r3.
    do_write(4'd3, 32'h11111111, "r3_init");
`ifdef RB_WR_BYPASS_EN
    exp35 = 32'h22222222;
`else
    exp35 = 32'h11111111;
`endif
    rd_addr = 4'd3;
    wr_addr = 4'd3;
    wr_data = 32'h22222222;
    rd_trig = ~rd_trig;
    wr_trig = ~wr_trig;
    n = 0;
    while (((rd_ready !== 1'b1) || (wr_ack !== wr_trig)) && (n < 20)) begin
      tick();
      n++;
    end
    check("same_edge_done", 64'(n), 64'd5);
    check("same_edge_data", 64'(rd_data), 64'(exp35));
    ref_regs[3] = 32'h22222222;
    do_read(4'd3, "r3_after");

    // Reset during write SYNC of r7.
    wr_addr = 4'd7;
    wr_data = 32'hAAAA5555;
    wr_trig = ~wr_trig;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    #1;
    check("abort_ack_eq_trig", 64'(wr_ack), 64'(wr_trig));
    check("abort_ready",       64'(rd_ready), 64'd1);
    repeat (10) tick();
    check("abort_no_late_commit", 64'(wr_ack), 64'(wr_trig));
    do_read(4'd7, "r7_after_abort");

    // Back-to-back read toggles: r1 then r2.
    do_write(4'd1, 32'h0101A0A0, "r1");
    do_write(4'd2, 32'h0202B0B0, "r2");
    v1 = ref_regs[1];
    v2 = ref_regs[2];
    rd_addr = 4'd1;
    rd_trig = ~rd_trig;
    tick();                                  // edge0 samples first toggle
    rd_trig = ~rd_trig;
    #1;
    check("b2b_ready_even_toggles", 64'(rd_ready), 64'd1);
    repeat (3) tick();                       // edges 1..3: first capture
    check("b2b_first_data", 64'(rd_data), 64'(v1));
    rd_addr = 4'd2;
    tick();                                  // edge4: first response
    check("b2b_second_pending", 64'(rd_ready), 64'd0);
    repeat (3) tick();                       // edges 5..7: second capture
    check("b2b_second_data", 64'(rd_data), 64'(v2));
    tick();                                  // edge8: second response
    check("b2b_ready_end", 64'(rd_ready), 64'd1);

    // Randomized traffic against the array model.
    for (int k = 0; k < 30; k++) begin
      op = int'($urandom_range(0, 2));
      wa = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (op == 0) begin
        do_write(wa, wd, "rnd");
      end else if (op == 1) begin
        do_read(wa, "rnd");
      end else begin
        ra = 4'((int'(wa) + int'($urandom_range(1, 15))) % 16);
        old_rd = ref_regs[ra];
        rd_addr = ra;
        wr_addr = wa;
        wr_data = wd;
        rd_trig = ~rd_trig;
        wr_trig = ~wr_trig;
        n = 0;
        while (((rd_ready !== 1'b1) || (wr_ack !== wr_trig)) && (n < 20)) begin
          tick();
          n++;
        end
        check("rnd_concurrent_done", 64'(n), 64'd5);
        check("rnd_concurrent_data", 64'(rd_data), 64'(old_rd));
        ref_regs[wa] = wd;
      end
    end
    for (int i = 0; i < 16; i++) do_read(4'(i), "final_sweep");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_bank_responder.md
REG_BANK_RESPONDER -- requirements
Module: reg_bank_responder

Interface
REQ-001 Parameter DW, 32, data word width in bits.
REQ-002 Parameter NREGS, 16, number of architectural registers; address width is log2(NREGS) = 4.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 rd_trig  input  1  read request toggle from the decode stage; each edge, rising or falling, is one request.
REQ-006 rd_addr  input  4  read register index; stable from the rd_trig edge until rd_ready is high.
REQ-007 rd_data  output  DW  read result; valid while rd_ready is high.
REQ-008 rd_ready  output  1  high when no read is outstanding; defined as NOT(rd_trig XOR rd_ack_phase).
REQ-009 wr_trig  input  1  write request toggle from writeback; each edge is one request.
REQ-010 wr_addr  input  4  write register index; stable until wr_ack equals wr_trig.
REQ-011 wr_data  input  DW  write value; stable until wr_ack equals wr_trig.
REQ-012 wr_ack  output  1  write acknowledge toggle; equals wr_trig once the write has committed.

Function
REQ-013 The block SHALL pass rd_trig and wr_trig each through a 2-flop synchronizer. A request is detected when the sync2 output differs from the stored ack phase.
REQ-014 rd_ready SHALL fall combinationally on the rd_trig edge, with no clock required, so that a requester that waits on level ready never sees a stale high.
REQ-015 Read FSM states are IDLE, SYNC, READ and RESP.
  - IDLE->SYNC on a raw rd_trig/phase mismatch.
  - SYNC->READ when sync2 differs from the phase.
  - READ: capture regs[rd_addr] into the rd_data register.
  - RESP: toggle rd_ack_phase, return to IDLE.
REQ-016 Read latency SHALL be 4 clk edges from the first edge sampling the new rd_trig to rd_ready high. rd_data SHALL change only in READ.
REQ-017 Write FSM states are IDLE, SYNC and COMMIT. In COMMIT it writes regs[wr_addr] = wr_data and toggles wr_ack on the same edge. Write latency SHALL be 3 clk edges.
REQ-018 The read and write FSMs SHALL run independently and concurrently. There is one write port and one read port; no arbitration stalls either port.
REQ-019 A READ and a COMMIT to the same address on the same edge is resolved by REQ-027/REQ-028. A READ and a COMMIT to different addresses are both performed.
REQ-020 An rd_trig edge that arrives while a read is outstanding is a protocol violation. The block SHALL complete the current read, then detect the mismatch and serve one further read. No request is lost when the toggle count is odd.
REQ-021 The block SHALL not reduce the index modulo NREGS; all 16 indices map directly.

Reset
REQ-022 While reset is high, on each clk edge, every register in regs SHALL clear to 0, rd_data SHALL clear to 0, and both FSMs SHALL go to IDLE.
REQ-023 While reset is high, the synchronizer flops and rd_ack_phase SHALL load the raw rd_trig, and wr_ack SHALL load the raw wr_trig. No phantom request is detected after reset deasserts, and rd_ready is high.
REQ-024 Reset asserted mid-read or mid-write SHALL abort the operation. An aborted write SHALL not modify regs.
REQ-025 In the first cycle after reset, rd_ready is 1, rd_data is 0 and wr_ack equals wr_trig.

Configuration
REQ-026 The macro RB_WR_BYPASS_EN selects behaviour for a READ and a COMMIT to the same address on the same edge.
REQ-027 With RB_WR_BYPASS_EN defined, rd_data SHALL capture wr_data, i.e. the new value.
REQ-028 Without RB_WR_BYPASS_EN, rd_data SHALL capture the old regs value, and the bypass mux SHALL be absent.

Structure
REQ-029 A shared package rb_pkg SHALL hold DW, NREGS, the address width, and the enumerated types for the read and write FSM states.
REQ-030 One sub-module, toggle_sync, SHALL implement the 2-flop synchronizer with edge/phase compare. It is instantiated twice, once for read and once for write.
REQ-031 The register storage SHALL be a flop array inside reg_bank_responder; no RAM macro is used.

Verification
REQ-032 Reset with rd_trig=1 and wr_trig=0, then release -> rd_ready=1, wr_ack=0, rd_data=0, and no register changes for 20 cycles.
REQ-033 Write 0xDEADBEEF to r5 via a wr_trig toggle -> wr_ack toggles exactly 3 edges later. A subsequent read of r5 -> rd_ready falls immediately, rises 4 edges later, and rd_data=0xDEADBEEF.
REQ-034 Read r0 after reset -> rd_data=0x00000000. Write then read r15=0x80000001 -> rd_data=0x80000001, with r14 unchanged.
REQ-035 r3=0x11111111; write 0x22222222 to r3 timed so COMMIT and READ share an edge -> rd_data=0x22222222 with RB_WR_BYPASS_EN, 0x11111111 without.
REQ-036 Assert reset during the SYNC state of a write of 0xAAAA5555 to r7 -> r7 stays 0, wr_ack equals wr_trig, and there is no later commit.
REQ-037 Toggle rd_trig twice 1 cycle apart for r1 and then r2 -> two reads complete in order, and rd_ready ends high.
